// File: rtl/pc8e_pkg.sv
// pc8e_pkg -- shared parameters for the PC8E paper-tape reader/punch.
//   Major-state codes driven by the CPU sequencer, IOT opcode and device
//   codes, reader/punch FSM state types and the IOT field decoder.
//   Instruction words use PDP-8 bit numbering: bit 0 is the MSB, bit 11 the LSB.
package pc8e_pkg;

  // Major-state codes as presented on the 5-bit state bus (one-hot).
  typedef enum logic [4:0] {
    MS_F1 = 5'b00001,
    MS_F2 = 5'b00010,
    MS_F3 = 5'b00100,
    MS_D  = 5'b01000,
    MS_E  = 5'b10000
  } major_state_e;

  localparam logic [2:0] OPC_IOT = 3'o6;
  localparam logic [5:0] DEV_RDR = 6'o01;
  localparam logic [5:0] DEV_PUN = 6'o02;

  typedef enum logic {
    RD_IDLE,
    RD_REQ
  } rd_state_e;

  typedef enum logic {
    PU_IDLE,
    PU_SEND
  } pu_state_e;

  // Decoded IOT micro-operations for one device:
  //   op_zero : operate field 000 (RPE / PCE)
  //   skip    : bit 11 (RSF / PSF)
  //   clr     : bit 10 (RRB / PCF)
  //   go      : bit 9  (RFC / PPC)
  typedef struct packed {
    logic op_zero;
    logic skip;
    logic clr;
    logic go;
  } iot_dec_t;

  function automatic iot_dec_t iot_decode(input logic [4:0]  st,
                                          input logic [0:11] ins,
                                          input logic [5:0]  dev);
    iot_dec_t d;
    logic     sel;
    sel       = (st == MS_F3) && (ins[0:2] == OPC_IOT) && (ins[3:8] == dev);
    d.op_zero = sel && (ins[9:11] == 3'b000);
    d.skip    = sel && ins[11];
    d.clr     = sel && ins[10];
    d.go      = sel && ins[9];
    return d;
  endfunction

endpackage

// File: rtl/pc8e_punch.sv
// pc8e_punch -- paper-tape punch buffer, handshake FSM and done flag.
//   clk          : system clock, rising edge
//   resetn       : asynchronous active-low reset
//   i_clear      : synchronous clear (flag low, FSM idle)
//   i_pcf        : clear punch flag (IOT bit 10, device 02)
//   i_ppc        : load buffer and start a punch (IOT bit 9, device 02)
//   i_data       : character to load (AC bits 4..11)
//   i_pun_ready  : punch accepts the presented character
//   o_pun_valid  : character present to the punch
//   o_pun_data   : buffered character, held stable while o_pun_valid
//   o_pun_flag   : punch done flag
module pc8e_punch
  import pc8e_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clear,
  input  logic       i_pcf,
  input  logic       i_ppc,
  input  logic [0:7] i_data,
  input  logic       i_pun_ready,
  output logic       o_pun_valid,
  output logic [0:7] o_pun_data,
  output logic       o_pun_flag
);

  pu_state_e  r_state;
  logic       r_valid;
  logic       r_flag;
  logic [0:7] r_pbuf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= PU_IDLE;
      r_valid <= 1'b0;
      r_flag  <= 1'b0;
      r_pbuf  <= '0;
    end else if (i_clear) begin
      r_state <= PU_IDLE;
      r_valid <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      case (r_state)
        PU_IDLE: begin
          if (i_pcf) r_flag <= 1'b0;
          if (i_ppc) begin
            r_pbuf  <= i_data;
            r_state <= PU_SEND;
            r_valid <= 1'b1;
          end
        end
        PU_SEND: begin
          // A PPC arriving here is dropped; completion beats a same-edge PCF.
          if (i_pun_ready) begin
            r_flag  <= 1'b1;
            r_state <= PU_IDLE;
            r_valid <= 1'b0;
          end else if (i_pcf) begin
            r_flag <= 1'b0;
          end
        end
        default: begin
          r_state <= PU_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pun_valid = r_valid;
  assign o_pun_data  = r_pbuf;
  assign o_pun_flag  = r_flag;

endmodule

// File: rtl/pc8e.sv
// pc8e -- PDP-8 paper-tape reader (device 01) and punch (device 02) IOT block.
//   clk         : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   clear       : synchronous CAF / front-panel clear, one clk wide
//   state       : major-state code (pc8e_pkg::major_state_e)
//   instruction : current instruction word, bits [0:11]
//   ac          : accumulator, bits [0:11]
//   pt_bus      : data ORed into the AC input mux (RRB only, F3 only)
//   skip        : IOT skip request (F3 only)
//   interrupt   : int_ena & (reader flag | punch flag), from registers
//   rdr_req / rdr_valid / rdr_data : reader character handshake
//   pun_valid / pun_ready / pun_data : punch character handshake
// Build option: define PC8E_PUNCH_EN to include the punch (pc8e_punch).
//   Without it device 02 IOTs are no-ops and the punch outputs are tied low.
module pc8e
  import pc8e_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic [4:0]  state,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  output logic [0:11] pt_bus,
  output logic        skip,
  output logic        interrupt,
  output logic        rdr_req,
  input  logic        rdr_valid,
  input  logic [0:7]  rdr_data,
  output logic        pun_valid,
  input  logic        pun_ready,
  output logic [0:7]  pun_data
);

  iot_dec_t   w_rdr;
  logic       w_rd_done;
  logic       w_pce;
  logic       w_psf;
  logic       w_pun_flag;

  rd_state_e  r_rd_state;
  logic       r_rdr_req;
  logic       r_rdr_flag;
  logic [0:7] r_rbuf;
  logic       r_int_ena;

  assign w_rdr     = iot_decode(state, instruction, DEV_RDR);
  assign w_rd_done = (r_rd_state == RD_REQ) && rdr_valid;

`ifdef PC8E_PUNCH_EN
  iot_dec_t w_pun;
  logic     w_unused_ac;

  assign w_pun       = iot_decode(state, instruction, DEV_PUN);
  assign w_pce       = w_pun.op_zero;
  assign w_psf       = w_pun.skip;
  assign w_unused_ac = &{1'b0, ac[0:3]};

  pc8e_punch u_punch (
    .clk         (clk),
    .resetn      (resetn),
    .i_clear     (clear),
    .i_pcf       (w_pun.clr),
    .i_ppc       (w_pun.go),
    .i_data      (ac[4:11]),
    .i_pun_ready (pun_ready),
    .o_pun_valid (pun_valid),
    .o_pun_data  (pun_data),
    .o_pun_flag  (w_pun_flag)
  );
`else
  logic w_unused_pun;

  assign w_pce        = 1'b0;
  assign w_psf        = 1'b0;
  assign w_pun_flag   = 1'b0;
  assign pun_valid    = 1'b0;
  assign pun_data     = '0;
  assign w_unused_pun = &{1'b0, pun_ready, ac};
`endif

  // Reader FSM, buffer and flag. rdr_req is registered alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= RD_IDLE;
      r_rdr_req  <= 1'b0;
      r_rdr_flag <= 1'b0;
      r_rbuf     <= '0;
    end else if (clear) begin
      r_rd_state <= RD_IDLE;
      r_rdr_req  <= 1'b0;
      r_rdr_flag <= 1'b0;
    end else begin
      // Character arrival beats a same-edge RRB/RFC flag clear.
      if (w_rd_done)
        r_rdr_flag <= 1'b1;
      else if (w_rdr.clr || w_rdr.go)
        r_rdr_flag <= 1'b0;

      case (r_rd_state)
        RD_IDLE: begin
          if (w_rdr.go) begin
            r_rd_state <= RD_REQ;
            r_rdr_req  <= 1'b1;
          end
        end
        RD_REQ: begin
          // RFC here does not restart the fetch.
          if (rdr_valid) begin
            r_rbuf     <= rdr_data;
            r_rd_state <= RD_IDLE;
            r_rdr_req  <= 1'b0;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_rdr_req  <= 1'b0;
        end
      endcase
    end
  end

  // Interrupt enable: RPE sets, PCE clears, reset and clear both set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_int_ena <= 1'b1;
    else if (clear)
      r_int_ena <= 1'b1;
    else if (w_rdr.op_zero)
      r_int_ena <= 1'b1;
    else if (w_pce)
      r_int_ena <= 1'b0;
  end

  assign rdr_req   = r_rdr_req;
  assign interrupt = r_int_ena & (r_rdr_flag | w_pun_flag);
  assign skip      = (w_rdr.skip & r_rdr_flag) | (w_psf & w_pun_flag);
  assign pt_bus    = w_rdr.clr ? {4'b0000, r_rbuf} : '0;

endmodule

// File: tb/tb_pc8e.sv
// tb_pc8e -- self-checking bench for pc8e: directed vector table, hand
// sequences for handshake corner cases, and randomized traffic against a
// behavioural model of the reader/punch rules.
module tb_pc8e;
  import pc8e_pkg::*;

`ifdef PC8E_PUNCH_EN
  localparam bit PUNCH = 1'b1;
`else
  localparam bit PUNCH = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        clear;
  logic [4:0]  state;
  logic [0:11] instruction;
  logic [0:11] ac;
  logic [0:11] pt_bus;
  logic        skip;
  logic        interrupt;
  logic        rdr_req;
  logic        rdr_valid;
  logic [0:7]  rdr_data;
  logic        pun_valid;
  logic        pun_ready;
  logic [0:7]  pun_data;

  pc8e dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .state       (state),
    .instruction (instruction),
    .ac          (ac),
    .pt_bus      (pt_bus),
    .skip        (skip),
    .interrupt   (interrupt),
    .rdr_req     (rdr_req),
    .rdr_valid   (rdr_valid),
    .rdr_data    (rdr_data),
    .pun_valid   (pun_valid),
    .pun_ready   (pun_ready),
    .pun_data    (pun_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the device registers.
  bit m_rflag, m_pflag, m_ie, m_rbusy, m_pbusy;
  int m_rbuf, m_pbuf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rflag = 0; m_pflag = 0; m_ie = 1; m_rbusy = 0; m_pbusy = 0;
    m_rbuf = 0; m_pbuf = 0;
  endtask

  // One clock: drive inputs, check combinational outputs before the edge,
  // advance the model across the edge, check registered outputs after it.
  task automatic apply(input logic [4:0] st, input logic [11:0] ins, input logic [11:0] a,
                       input logic rv, input logic [7:0] rd, input logic pr, input logic clr,
                       output logic s_skip, output logic [11:0] s_pt);
    int iv, op, dev, opc;
    bit iot, rsel, psel, rdone, pdone, e_skip;
    int e_pt;
    state = st; instruction = ins; ac = a;
    rdr_valid = rv; rdr_data = rd; pun_ready = pr; clear = clr;
    iv  = int'(ins);
    op  = iv % 8;
    dev = (iv / 8) % 64;
    opc = iv / 512;
    iot  = (st == MS_F3) && (opc == 6);
    rsel = iot && (dev == 1);
    psel = PUNCH && iot && (dev == 2);
    e_skip = (op % 2 == 1) && ((rsel && m_rflag) || (psel && m_pflag));
    e_pt   = (rsel && ((op / 2) % 2 == 1)) ? m_rbuf : 0;
    rdone  = m_rbusy && rv;
    pdone  = m_pbusy && pr;
    #1;
    check("skip", 32'(skip), 32'(e_skip));
    check("pt_bus", 32'(pt_bus), e_pt);
    s_skip = skip;
    s_pt   = pt_bus;
    @(posedge clk);
    if (clr) begin
      m_rflag = 0; m_pflag = 0; m_ie = 1; m_rbusy = 0; m_pbusy = 0;
    end else begin
      if (rdone) m_rflag = 1;
      else if (rsel && (op & 6) != 0) m_rflag = 0;
      if (rdone) m_rbuf = int'(rd);
      if (m_rbusy) m_rbusy = !rv;
      else         m_rbusy = rsel && (op & 4) != 0;
      if (rsel && op == 0) m_ie = 1;
      if (psel && op == 0) m_ie = 0;
      if (pdone) m_pflag = 1;
      else if (psel && (op & 2) != 0) m_pflag = 0;
      if (m_pbusy) m_pbusy = !pr;
      else if (psel && (op & 4) != 0) begin
        m_pbuf  = int'(a) % 256;
        m_pbusy = 1;
      end
    end
    #1;
    check("rdr_req", 32'(rdr_req), 32'(m_rbusy));
    check("pun_valid", 32'(pun_valid), 32'(m_pbusy));
    check("pun_data", 32'(pun_data), m_pbuf);
    check("interrupt", 32'(interrupt), 32'(m_ie && (m_rflag || m_pflag)));
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  st;
    logic [11:0] ins;
    logic        rv;
    logic [7:0]  rd;
    logic        e_skip;
    logic [11:0] e_pt;
    logic        e_req;
    logic        e_int;
  } vec_t;

  vec_t        vecs[18];
  logic        s_skip;
  logic [11:0] s_pt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // st, ins, rv, rd | skip, pt_bus (pre-edge) | rdr_req, interrupt (post-edge)
    vecs[0]  = '{MS_F3, 12'o6014, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0}; // RFC
    vecs[1]  = '{MS_F1, 12'o0000, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[2]  = '{MS_F1, 12'o0000, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[3]  = '{MS_F1, 12'o0000, 1'b1, 8'h5A, 1'b0, 12'h000, 1'b0, 1'b1}; // char arrives
    vecs[4]  = '{MS_F3, 12'o6011, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 1'b1}; // RSF skips
    vecs[5]  = '{MS_F2, 12'o6011, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1}; // not F3
    vecs[6]  = '{MS_F3, 12'o6012, 1'b0, 8'h00, 1'b0, 12'h05A, 1'b0, 1'b0}; // RRB
    vecs[7]  = '{MS_F3, 12'o6011, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[8]  = '{MS_F3, 12'o6014, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[9]  = '{MS_F1, 12'o0000, 1'b1, 8'h3C, 1'b0, 12'h000, 1'b0, 1'b1};
    vecs[10] = '{MS_F3, 12'o6020, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, !PUNCH}; // PCE
    vecs[11] = '{MS_F3, 12'o6010, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1};   // RPE
    vecs[12] = '{MS_F3, 12'o6016, 1'b0, 8'h00, 1'b0, 12'h03C, 1'b1, 1'b0};   // RRB+RFC
    vecs[13] = '{MS_F1, 12'o0000, 1'b1, 8'hA5, 1'b0, 12'h000, 1'b0, 1'b1};
    vecs[14] = '{MS_F3, 12'o6012, 1'b0, 8'h00, 1'b0, 12'h0A5, 1'b0, 1'b0};
    vecs[15] = '{MS_F3, 12'o6014, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[16] = '{MS_F3, 12'o6014, 1'b1, 8'h11, 1'b0, 12'h000, 1'b0, 1'b1};   // RFC on arrival edge
    vecs[17] = '{MS_F3, 12'o6012, 1'b0, 8'h00, 1'b0, 12'h011, 1'b0, 1'b0};   // no refetch

    resetn = 1'b0; clear = 1'b0; state = MS_F1; instruction = '0; ac = '0;
    rdr_valid = 1'b0; rdr_data = '0; pun_ready = 1'b0;
    model_reset();
    #3;
    check("reset_rdr_req", 32'(rdr_req), 0);
    check("reset_pun_valid", 32'(pun_valid), 0);
    check("reset_interrupt", 32'(interrupt), 0);
    check("reset_pun_data", 32'(pun_data), 0);
    state = MS_F3; instruction = 12'o6012;
    #1;
    check("reset_pt_bus", 32'(pt_bus), 0);
    instruction = 12'o6011;
    #1;
    check("reset_skip", 32'(skip), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].st, vecs[i].ins, 12'o0000, vecs[i].rv, vecs[i].rd, 1'b0, 1'b0, s_skip, s_pt);
      check($sformatf("tbl%0d_skip", i), 32'(s_skip), 32'(vecs[i].e_skip));
      check($sformatf("tbl%0d_pt", i), 32'(s_pt), 32'(vecs[i].e_pt));
      check($sformatf("tbl%0d_req", i), 32'(rdr_req), 32'(vecs[i].e_req));
      check($sformatf("tbl%0d_int", i), 32'(interrupt), 32'(vecs[i].e_int));
    end

    // Reset asserted mid-REQ, released while rdr_valid is high.
    apply(MS_F3, 12'o6014, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("midreq_req_before", 32'(rdr_req), 1);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("midreq_rst_req", 32'(rdr_req), 0);
    check("midreq_rst_int", 32'(interrupt), 0);
    @(negedge clk);
    rdr_valid = 1'b1;
    resetn = 1'b1;
    apply(MS_F1, 12'o0000, 12'o0, 1'b1, 8'h77, 1'b0, 1'b0, s_skip, s_pt);
    check("rst_release_int", 32'(interrupt), 0);
    apply(MS_F3, 12'o6011, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("rst_release_skip", 32'(s_skip), 0);

    // Clear mid-REQ: request drops, late character does not set the flag.
    apply(MS_F3, 12'o6014, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    apply(MS_F3, 12'o6014, 12'o0, 1'b0, 8'h00, 1'b0, 1'b1, s_skip, s_pt);
    check("clr_req", 32'(rdr_req), 0);
    apply(MS_F1, 12'o0000, 12'o0, 1'b1, 8'h42, 1'b0, 1'b0, s_skip, s_pt);
    check("clr_late_int", 32'(interrupt), 0);

`ifdef PC8E_PUNCH_EN
    apply(MS_F3, 12'o6026, 12'o7777, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt); // PLS
    check("pls_valid", 32'(pun_valid), 1);
    check("pls_data", 32'(pun_data), 32'hFF);
    apply(MS_F1, 12'o0000, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    apply(MS_F3, 12'o6024, 12'o0123, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt); // PPC in SEND
    check("ppc_send_data", 32'(pun_data), 32'hFF);
    apply(MS_F1, 12'o0000, 12'o0, 1'b0, 8'h00, 1'b1, 1'b0, s_skip, s_pt);
    check("pun_done_valid", 32'(pun_valid), 0);
    check("pun_done_int", 32'(interrupt), 1);
    apply(MS_F3, 12'o6021, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("psf_skip", 32'(s_skip), 1);
    apply(MS_F3, 12'o6020, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("pce_int", 32'(interrupt), 0);
    apply(MS_F3, 12'o6010, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("rpe_int", 32'(interrupt), 1);
    apply(MS_F3, 12'o6022, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("pcf_int", 32'(interrupt), 0);
    apply(MS_F3, 12'o6024, 12'o0077, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    apply(MS_F3, 12'o6022, 12'o0, 1'b0, 8'h00, 1'b1, 1'b0, s_skip, s_pt); // PCF on done edge
    check("pcf_done_int", 32'(interrupt), 1);
    apply(MS_F3, 12'o6026, 12'o0123, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("ppc2_data", 32'(pun_data), 32'h53);
    apply(MS_F1, 12'o0000, 12'o0, 1'b0, 8'h00, 1'b0, 1'b1, s_skip, s_pt); // clear mid-SEND
    check("clr_send_valid", 32'(pun_valid), 0);
    apply(MS_F1, 12'o0000, 12'o0, 1'b0, 8'h00, 1'b1, 1'b0, s_skip, s_pt);
    check("clr_send_int", 32'(interrupt), 0);
`else
    apply(MS_F3, 12'o6024, 12'o7777, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("nopun_valid", 32'(pun_valid), 0);
    apply(MS_F1, 12'o0000, 12'o0, 1'b0, 8'h00, 1'b1, 1'b0, s_skip, s_pt);
    apply(MS_F3, 12'o6021, 12'o0, 1'b0, 8'h00, 1'b0, 1'b0, s_skip, s_pt);
    check("nopun_psf_skip", 32'(s_skip), 0);
    check("nopun_int", 32'(interrupt), 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  st;
      logic [2:0]  opc;
      logic [5:0]  dev;
      logic [2:0]  op;
      case ($urandom_range(0, 7))
        0:       st = MS_F1;
        1:       st = MS_F2;
        2:       st = MS_D;
        3:       st = MS_E;
        default: st = MS_F3;
      endcase
      opc = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'o6;
      dev = 6'($urandom_range(0, 3));
      op  = 3'($urandom_range(0, 7));
      apply(st, {opc, dev, op}, 12'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 63) == 0), s_skip, s_pt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc8e.md
PC8E -- requirements
Module: pc8e

Interface
REQ-001 SHALL have port clk, input, 1, system clock (100 MHz domain); all state in this block is clocked on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clear, input, 1, synchronous CAF/front-panel clear pulse, one clk wide.
REQ-004 SHALL have port state, input, 5, major-state code; encoding is taken from the shared parameters.
REQ-005 SHALL have port instruction, input, [0:11], current instruction word (memory data out).
REQ-006 SHALL have port ac, input, [0:11], accumulator value.
REQ-007 SHALL have port pt_bus, output, [0:11], data ORed into the AC input mux.
REQ-008 SHALL have port skip, output, 1, skip request to the IOT skip mux.
REQ-009 SHALL have port interrupt, output, 1, interrupt request.
REQ-010 SHALL have port rdr_req, output, 1, reader character request.
REQ-011 SHALL have port rdr_valid, input, 1, reader character present.
REQ-012 SHALL have port rdr_data, input, [0:7], reader character.
REQ-013 SHALL have port pun_valid, output, 1, punch character present.
REQ-014 SHALL have port pun_ready, input, 1, punch accepts character.
REQ-015 SHALL have port pun_data, output, [0:7], punch character.

Function
REQ-016 SHALL execute an IOT only when state==F3 and instruction[0:2]==6, with device 01 for the reader and 02 for the punch; actions take effect at the rising edge that ends F3.
REQ-017 SHALL, in F3, drive skip and pt_bus combinationally; both SHALL be 0 in every other state.
REQ-018 SHALL implement reader IOTs as: 6010 RPE sets int_ena; 6011 RSF skips when rdr_flag=1; bit 10 (RRB) drives pt_bus={4'b0,rbuf} and clears rdr_flag; bit 9 (RFC) clears rdr_flag and starts a fetch.
REQ-019 SHALL implement punch IOTs as: 6020 PCE clears int_ena; 6021 PSF skips when pun_flag=1; bit 10 (PCF) clears pun_flag; bit 9 (PPC) loads pbuf=ac[4:11] and starts a punch; 6026 performs clear-then-load.
REQ-020 SHALL run the reader FSM as IDLE -> REQ on RFC; in REQ, hold rdr_req=1 until rdr_valid; on that edge load rbuf=rdr_data, set rdr_flag, and return to IDLE.
REQ-021 SHALL run the punch FSM as IDLE -> SEND on PPC; in SEND, hold pun_valid=1 with pun_data=pbuf stable until pun_ready; on that edge set pun_flag and return to IDLE.
REQ-022 SHALL ignore an RFC issued while in REQ (no restart); its flag-clear still applies, but a same-edge character arrival sets the flag (set wins).
REQ-023 SHALL discard a PPC issued while in SEND, leaving pbuf unchanged, while its clear part still applies; a same-edge completion sets the flag (set wins).
REQ-024 SHALL ignore rdr_valid in IDLE and pun_ready in IDLE.
REQ-025 SHALL drive interrupt = int_ena & (rdr_flag | pun_flag) from registers, with no combinational path from inputs.
REQ-026 SHALL, on clear, zero both flags, set int_ena=1, and return both FSMs to IDLE, dropping rdr_req and pun_valid on the next edge; clear overrides any same-cycle IOT.

Reset
REQ-027 SHALL, on resetn low, immediately set rdr_flag=0, pun_flag=0, int_ena=1, rbuf=0, pbuf=0, both FSMs to IDLE, and rdr_req=pun_valid=interrupt=0; skip and pt_bus are then 0.
REQ-028 SHALL abandon any handshake in progress when reset is asserted mid-handshake, and SHALL not set a flag on resetn release.

Configuration
REQ-029 SHALL, with PC8E_PUNCH_EN defined, provide the full punch function.
REQ-030 SHALL, without PC8E_PUNCH_EN defined, treat device 02 IOTs as no-ops, tie pun_valid=0, pun_data=0 and pun_flag=0, and make interrupt depend on the reader only.

Structure
REQ-031 SHALL take the major-state codes (F3) and device codes 01 and 02 from the shared parameters file.
REQ-032 SHALL place the punch buffer, FSM and flag in sub-module pc8e_punch, instantiated only under PC8E_PUNCH_EN.

Verification
REQ-033 SHALL cover reader fetch: RFC(6014), then rdr_valid with rdr_data=0x5A after 3 cycles -> rdr_req high for 3 cycles, rdr_flag=1, interrupt=1; RSF skip=1; RRB pt_bus=0x05A and the flag clears.
REQ-034 SHALL cover punch: ac=0o7777 with PLS(6026), pun_ready after 2 cycles -> pun_data=0xFF held, pun_flag=1; PCF -> interrupt=0.
REQ-035 SHALL cover PCE(6020) with a flag set -> interrupt=0, and RPE(6010) -> interrupt=1.
REQ-036 SHALL cover boundaries: PPC with ac=0o0123 during SEND -> pbuf retains its old value; RFC on the rdr_valid edge -> rdr_flag=1 and no new request.
REQ-037 SHALL cover reset mid-REQ and clear mid-SEND -> rdr_req and pun_valid drop and flags=0; with PC8E_PUNCH_EN undefined, PSF -> skip=0.
